// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter slice.
// Contents: default sizing parameters and the arbiter FSM state encoding.
package adder_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_ID_W    = 2;

  // IDLE: arbitrating, BUSY: add in flight, DONE: result/ack presented.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder arbiter.
// Signals:
//   req       requester -> arbiter  per-requester level request
//   a_in/b_in requester -> arbiter  packed operands, slice i*WIDTH +: WIDTH
//   gnt       arbiter -> requester  one-hot grant while the op is in flight
//   ack       arbiter -> requester  one-hot one-cycle completion pulse
//   sum       arbiter -> requester  registered result
//   sum_id    arbiter -> requester  owner of sum
//   sum_valid arbiter -> requester  high together with ack
//   busy      arbiter -> requester  arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = DEFAULT_ID_W
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         sum;
  logic [ID_W-1:0]          sum_id;
  logic                     sum_valid;
  logic                     busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, ack, sum, sum_id, sum_valid, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, ack, sum, sum_id, sum_valid, busy
  );

endinterface

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req starting at index ptr and
// wrapping modulo NUM_REQ, reporting the first asserted index.
// Ports: req (requests), ptr (scan start), id (winner), found (any req set).
module rr_picker
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    id,
  output logic               found
);

  // First hit wins; later hits are masked by found.
  always_comb begin
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        id    = ID_W'((int'(ptr) + k) % NUM_REQ);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ripple_adder.sv
// Plain ripple-carry adder, sum = (a + b) mod 2^WIDTH, no carry out.
// Ports: a, b (WIDTH operands), sum (WIDTH result).
module ripple_adder
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic carry;

  // Bit-serial carry chain; the carry out of the top bit is discarded.
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple_adder among NUM_REQ requesters.
// One operation takes three cycles: IDLE (arbitrate and capture operands),
// BUSY (add from captured operands), DONE (ack/sum_valid pulse).
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous active-high reset
//   bus    adder_arbiter_if slave modport (req/operands in, grant/result out)
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic            clock,
  input  logic            reset,
  adder_arbiter_if.slave  bus
);

  state_t               state;
  state_t               next_state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      id;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [ID_W-1:0]      win_id;
  logic                 win_found;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;
  logic [WIDTH-1:0]     add_out;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [NUM_REQ-1:0]   ack_reg;
  logic [WIDTH-1:0]     sum_reg;
  logic [ID_W-1:0]      sum_id_reg;
  logic                 valid_reg;
  logic                 busy_reg;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (bus.req),
    .ptr   (ptr),
    .id    (win_id),
    .found (win_found)
  );

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_out)
  );

  // Operand mux for the current arbitration winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == win_id) begin
        sel_a = bus.a_in[k*WIDTH +: WIDTH];
        sel_b = bus.b_in[k*WIDTH +: WIDTH];
      end else begin
        sel_a = sel_a;
        sel_b = sel_b;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          next_state = ST_BUSY;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_BUSY: next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, registered outputs and round-robin pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      id         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      gnt_reg    <= '0;
      ack_reg    <= '0;
      sum_reg    <= '0;
      sum_id_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            id       <= win_id;
            op_a     <= sel_a;
            op_b     <= sel_b;
            gnt_reg  <= onehot(win_id);
            busy_reg <= 1'b1;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        ST_BUSY: begin
          sum_reg    <= add_out;
          sum_id_reg <= id;
          valid_reg  <= 1'b1;
          ack_reg    <= onehot(id);
        end
        ST_DONE: begin
          gnt_reg   <= '0;
          ack_reg   <= '0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          // Rotate priority to just past the requester that was served.
          if (id == ID_W'(NUM_REQ - 1)) begin
            ptr <= '0;
          end else begin
            ptr <= id + ID_W'(1);
          end
        end
        default: begin
          gnt_reg   <= '0;
          ack_reg   <= '0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.ack       = ack_reg;
  assign bus.sum       = sum_reg;
  assign bus.sum_id    = sum_id_reg;
  assign bus.sum_valid = valid_reg;
  assign bus.busy      = busy_reg;

endmodule
